// File: rtl/reward_packer_if.sv
// reward_packer_if -- outbound packet bus of the reward packer.
//   master: drives pkt_valid and every packet field, samples pkt_ready.
//   slave : samples pkt_valid and the fields, drives pkt_ready.
//   A packet moves on the cycle where pkt_valid and pkt_ready are both high.
interface reward_packer_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [2:0]            rPacketType;
    logic [WORD_WIDTH-1:0] rSourceID;
    logic [WORD_WIDTH-1:0] rEnergyLeft;
    logic [WORD_WIDTH-1:0] rQValue;
    logic [WORD_WIDTH-1:0] rSourceHops;
    logic [WORD_WIDTH-1:0] rDestinationID;
    logic [WORD_WIDTH-1:0] rChosenCH;
    logic [WORD_WIDTH-1:0] rHopsFromCH;
    logic [WORD_WIDTH-1:0] rTimeslot;

    modport master (
        output pkt_valid, rPacketType, rSourceID, rEnergyLeft, rQValue, rSourceHops,
               rDestinationID, rChosenCH, rHopsFromCH, rTimeslot,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid, rPacketType, rSourceID, rEnergyLeft, rQValue, rSourceHops,
               rDestinationID, rChosenCH, rHopsFromCH, rTimeslot,
        output pkt_ready
    );
endinterface

// File: rtl/reward_packer.sv
// reward_packer -- builds one outbound packet (or a CHT burst) per en request.
//   clk, rst            : clock, synchronous active-high reset
//   en, fPacketType, iAmDestination, iHaveData, role, low_E : request + node state
//   myNodeID .. chosenHop : this node's information fields
//   neighborCount, nTableIndex, mNodeID, mChosenCH : neighbor table, 1-cycle read
//   pkt (master)        : packet bus with valid/ready handshake
//   busy, reward_done   : not-idle flag, one-cycle completion pulse
module reward_packer #(
    parameter  int WORD_WIDTH     = 16,
    parameter  int MAX_NEIGHBORS  = 32,
    parameter  int MAX_CH_HOPS    = 4,
    parameter  int TIMEOUT_CYCLES = 15,
    localparam int IDXW           = $clog2(MAX_NEIGHBORS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2:0]            fPacketType,
    input  logic                  iAmDestination,
    input  logic                  iHaveData,
    input  logic                  role,
    input  logic                  low_E,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] chosenHop,
    input  logic [IDXW-1:0]       neighborCount,
    output logic [IDXW-1:0]       nTableIndex,
    input  logic [WORD_WIDTH-1:0] mNodeID,
    input  logic [WORD_WIDTH-1:0] mChosenCH,
    reward_packer_if.master       pkt,
    output logic                  busy,
    output logic                  reward_done
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] PT_HB   = 3'b000;
    localparam logic [2:0] PT_INV  = 3'b010;
    localparam logic [2:0] PT_MR   = 3'b011;
    localparam logic [2:0] PT_CHT  = 3'b100;
    localparam logic [2:0] PT_DATA = 3'b101;
    localparam logic [2:0] PT_SOS  = 3'b110;
    localparam logic [2:0] PT_NONE = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_EMIT, S_CHT_RD, S_CHT_CHK, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [WORD_WIDTH-1:0] slot_q, slot_d;
    logic                  hb_lock_q, hb_lock_d, inv_sent_q, inv_sent_d;
    logic                  mr_run_q, mr_run_d, mr_pend_q, mr_pend_d;
    logic                  cht_run_q, cht_run_d, cht_pend_q, cht_pend_d;
    logic [TW-1:0]         mr_cnt_q, mr_cnt_d, cht_cnt_q, cht_cnt_d;
    logic                  valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [2:0]            type_q, type_d;
    logic [WORD_WIDTH-1:0] src_q, src_d, energy_q, energy_d, qval_q, qval_d;
    logic [WORD_WIDTH-1:0] shops_q, shops_d, dest_q, dest_d, chch_q, chch_d;
    logic [WORD_WIDTH-1:0] hopsch_q, hopsch_d, tslot_q, tslot_d;
    logic [WORD_WIDTH-1:0] hc_sel, ts_sel;
    logic                  emit, scan_step, scan_more;

    always_comb begin
        state_d    = state_q;    idx_d      = idx_q;      slot_d    = slot_q;
        hb_lock_d  = hb_lock_q;  inv_sent_d = inv_sent_q;
        mr_run_d   = mr_run_q;   mr_pend_d  = mr_pend_q;  mr_cnt_d  = mr_cnt_q;
        cht_run_d  = cht_run_q;  cht_pend_d = cht_pend_q; cht_cnt_d = cht_cnt_q;
        valid_d    = valid_q;    type_d     = type_q;
        src_d      = src_q;      energy_d   = energy_q;   qval_d    = qval_q;
        shops_d    = shops_q;    dest_d     = dest_q;     chch_d    = chch_q;
        hopsch_d   = hopsch_q;   tslot_d    = tslot_q;
        hc_sel     = '0;
        ts_sel     = '0;
        emit       = 1'b0;
        scan_step  = 1'b0;
        scan_more  = (idx_q + IDXW'(1)) < neighborCount;

        // Timers run independently of the FSM; expiry latches the pending flag.
        if (mr_run_q) begin
            mr_cnt_d = mr_cnt_q - TW'(1);
            if (mr_cnt_q == TW'(1)) begin
                mr_run_d  = 1'b0;
                mr_pend_d = 1'b1;
            end
        end
        if (cht_run_q) begin
            cht_cnt_d = cht_cnt_q - TW'(1);
            if (cht_cnt_q == TW'(1)) begin
                cht_run_d  = 1'b0;
                cht_pend_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: if (en) begin
                if (fPacketType == PT_HB && !hb_lock_q) begin
                    type_d = PT_HB; dest_d = '1; hb_lock_d = 1'b1; emit = 1'b1;
                end else if (role && !inv_sent_q) begin
                    type_d = PT_INV; dest_d = '1; inv_sent_d = 1'b1; emit = 1'b1;
                    cht_run_d = 1'b1; cht_cnt_d = TW'(TIMEOUT_CYCLES);
                end else if (!role && fPacketType == PT_INV &&
                             hopsFromCH < WORD_WIDTH'(MAX_CH_HOPS)) begin
                    type_d = PT_INV; dest_d = '1; hc_sel = hopsFromCH + WORD_WIDTH'(1);
                    emit = 1'b1;
                    if (!mr_run_q && !mr_pend_q) begin
                        mr_run_d = 1'b1; mr_cnt_d = TW'(TIMEOUT_CYCLES);
                    end
                end else if (!role && mr_pend_q) begin
                    type_d = PT_MR; dest_d = chosenCH; emit = 1'b1;
                end else if (role && cht_pend_q) begin
                    idx_d  = '0;
                    slot_d = WORD_WIDTH'(1);
                    if (neighborCount == '0) begin
                        cht_pend_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_CHT_RD;
                    end
                end else if ((iAmDestination && fPacketType == PT_DATA) || iHaveData) begin
                    type_d = low_E ? PT_SOS : PT_DATA;
                    dest_d = (hopsFromSink == WORD_WIDTH'(1)) ? '0 : chosenHop;
                    emit   = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_EMIT: if (pkt.pkt_ready) begin
                valid_d = 1'b0;
                if (type_q == PT_CHT) begin
                    scan_step = 1'b1;
                end else begin
                    state_d = S_DONE;
                    if (type_q == PT_DATA || type_q == PT_SOS) hb_lock_d = 1'b0;
                    if (type_q == PT_MR) mr_pend_d = 1'b0;
                end
            end
            // Table address was presented during CHT_RD; data is valid now.
            S_CHT_RD:  state_d = S_CHT_CHK;
            S_CHT_CHK: begin
                if (mChosenCH == myNodeID) begin
                    type_d = PT_CHT; dest_d = mNodeID; ts_sel = slot_q;
                    slot_d = slot_q + WORD_WIDTH'(1);
                    emit   = 1'b1;
                end else begin
                    scan_step = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            src_d    = myNodeID;     energy_d = myEnergy; qval_d  = myQValue;
            shops_d  = hopsFromSink; chch_d   = chosenCH; hopsch_d = hc_sel;
            tslot_d  = ts_sel;
            valid_d  = 1'b1;
            state_d  = S_EMIT;
        end

        if (scan_step) begin
            if (scan_more) begin
                idx_d   = idx_q + IDXW'(1);
                state_d = S_CHT_RD;
            end else begin
                cht_pend_d = 1'b0;
                state_d    = S_DONE;
            end
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE; idx_q <= '0; slot_q <= '0;
            hb_lock_q <= 1'b0; inv_sent_q <= 1'b0;
            mr_run_q <= 1'b0; mr_pend_q <= 1'b0; mr_cnt_q <= '0;
            cht_run_q <= 1'b0; cht_pend_q <= 1'b0; cht_cnt_q <= '0;
            valid_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
            type_q <= PT_NONE; dest_q <= '1;
            src_q <= '0; energy_q <= '0; qval_q <= '0; shops_q <= '0;
            chch_q <= '0; hopsch_q <= '0; tslot_q <= '0;
        end else begin
            state_q  <= state_d; idx_q <= idx_d; slot_q <= slot_d;
            hb_lock_q <= hb_lock_d; inv_sent_q <= inv_sent_d;
            mr_run_q <= mr_run_d; mr_pend_q <= mr_pend_d; mr_cnt_q <= mr_cnt_d;
            cht_run_q <= cht_run_d; cht_pend_q <= cht_pend_d; cht_cnt_q <= cht_cnt_d;
            valid_q <= valid_d; busy_q <= busy_d; done_q <= done_d;
            type_q <= type_d; dest_q <= dest_d;
            src_q <= src_d; energy_q <= energy_d; qval_q <= qval_d; shops_q <= shops_d;
            chch_q <= chch_d; hopsch_q <= hopsch_d; tslot_q <= tslot_d;
        end
    end

    assign pkt.pkt_valid      = valid_q;
    assign pkt.rPacketType    = type_q;
    assign pkt.rSourceID      = src_q;
    assign pkt.rEnergyLeft    = energy_q;
    assign pkt.rQValue        = qval_q;
    assign pkt.rSourceHops    = shops_q;
    assign pkt.rDestinationID = dest_q;
    assign pkt.rChosenCH      = chch_q;
    assign pkt.rHopsFromCH    = hopsch_q;
    assign pkt.rTimeslot      = tslot_q;
    assign nTableIndex        = idx_q;
    assign busy               = busy_q;
    assign reward_done        = done_q;
endmodule

// File: tb/tb_reward_packer.sv
// tb_reward_packer -- directed + randomized bench for reward_packer.
// A packet-level reference model predicts, per en request, the list of
// packets that must appear on the bus; timers are modelled as "armed at
// request edge E0, pending for any request edge later than E0+TIMEOUT".
module tb_reward_packer;
    localparam int W  = 16;
    localparam int T  = 15;
    localparam int NX = 6;

    logic clk, rst, en, iAmDestination, iHaveData, role, low_E;
    logic [2:0]    fPacketType;
    logic [W-1:0]  myNodeID, myEnergy, myQValue, hopsFromSink, chosenCH, hopsFromCH, chosenHop;
    logic [NX-1:0] neighborCount, nTableIndex;
    logic [W-1:0]  mNodeID, mChosenCH;
    logic          busy, reward_done;
    logic [W-1:0]  tbl_node [0:31];
    logic [W-1:0]  tbl_ch   [0:31];

    reward_packer_if #(.WORD_WIDTH(W)) pif ();

    reward_packer dut (
        .clk(clk), .rst(rst), .en(en), .fPacketType(fPacketType),
        .iAmDestination(iAmDestination), .iHaveData(iHaveData), .role(role), .low_E(low_E),
        .myNodeID(myNodeID), .myEnergy(myEnergy), .myQValue(myQValue),
        .hopsFromSink(hopsFromSink), .chosenCH(chosenCH), .hopsFromCH(hopsFromCH),
        .chosenHop(chosenHop), .neighborCount(neighborCount), .nTableIndex(nTableIndex),
        .mNodeID(mNodeID), .mChosenCH(mChosenCH), .pkt(pif),
        .busy(busy), .reward_done(reward_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Neighbor table RAM with one-cycle read latency.
    always @(posedge clk) begin
        mNodeID   <= tbl_node[nTableIndex[4:0]];
        mChosenCH <= tbl_ch[nTableIndex[4:0]];
    end

    typedef struct {
        logic [2:0]   t;
        logic [W-1:0] src, egy, q, sh, dst, ch, hc, ts;
        bit           full, hc_chk;
    } pkt_t;

    pkt_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // reference-model state
    bit hb_lock, inv_sent, mr_armed, cht_armed;
    int mr_t0, cht_t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hb_lock = 0; inv_sent = 0; mr_armed = 0; cht_armed = 0; mr_t0 = 0; cht_t0 = 0;
    endtask

    // Builds exp_q for a request sampled at edge E; scan=1 for a CHT scan.
    task automatic predict(input int E, output bit scan);
        pkt_t p;
        bit   mr_p, cht_p;
        int   slot;
        exp_q.delete();
        scan  = 0;
        p     = '{default: '0};
        p.src = myNodeID; p.egy = myEnergy; p.q = myQValue; p.sh = hopsFromSink;
        p.ch  = chosenCH; p.ts = '0; p.full = 1;
        mr_p  = mr_armed && (E > mr_t0 + T);
        cht_p = cht_armed && (E > cht_t0 + T);
        if (fPacketType == 3'b000 && !hb_lock) begin
            p.t = 3'b000; p.dst = '1; hb_lock = 1; exp_q.push_back(p);
        end else if (role && !inv_sent) begin
            p.t = 3'b010; p.dst = '1; p.hc = 0; p.hc_chk = 1; exp_q.push_back(p);
            inv_sent = 1; cht_armed = 1; cht_t0 = E;
        end else if (!role && fPacketType == 3'b010 && hopsFromCH < 4) begin
            p.t = 3'b010; p.dst = '1; p.hc = hopsFromCH + 1; p.hc_chk = 1; exp_q.push_back(p);
            if (!mr_armed) begin mr_armed = 1; mr_t0 = E; end
        end else if (!role && mr_p) begin
            p.t = 3'b011; p.dst = chosenCH; exp_q.push_back(p);
            mr_armed = 0;
        end else if (role && cht_p) begin
            scan = 1; slot = 1;
            for (int i = 0; i < int'(neighborCount); i++) begin
                if (tbl_ch[i] == myNodeID) begin
                    p.t = 3'b100; p.dst = tbl_node[i]; p.ts = W'(slot); p.full = 0;
                    exp_q.push_back(p);
                    slot++;
                end
            end
            cht_armed = 0;
        end else if ((iAmDestination && fPacketType == 3'b101) || iHaveData) begin
            p.t   = low_E ? 3'b110 : 3'b101;
            p.dst = (hopsFromSink == 1) ? '0 : chosenHop;
            exp_q.push_back(p);
            hb_lock = 0;
        end
    endtask

    task automatic check_pkt(input pkt_t e);
        chk("rPacketType", {29'b0, pif.rPacketType}, {29'b0, e.t});
        chk("rDestinationID", {16'b0, pif.rDestinationID}, {16'b0, e.dst});
        chk("rTimeslot", {16'b0, pif.rTimeslot}, {16'b0, e.ts});
        if (e.full) begin
            chk("rSourceID", {16'b0, pif.rSourceID}, {16'b0, e.src});
            chk("rEnergyLeft", {16'b0, pif.rEnergyLeft}, {16'b0, e.egy});
            chk("rQValue", {16'b0, pif.rQValue}, {16'b0, e.q});
            chk("rSourceHops", {16'b0, pif.rSourceHops}, {16'b0, e.sh});
            chk("rChosenCH", {16'b0, pif.rChosenCH}, {16'b0, e.ch});
        end
        if (e.hc_chk) chk("rHopsFromCH", {16'b0, pif.rHopsFromCH}, {16'b0, e.hc});
    endtask

    // Issue one en request at the current negedge and follow it to completion.
    task automatic run_txn(input int stall);
        bit scan;
        int w;
        predict(cyc + 1, scan);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0 || scan) begin
                w = 0;
                while (!pif.pkt_valid && !reward_done && w < 50) begin @(negedge clk); w++; end
            end
            chk("pkt_valid", {31'b0, pif.pkt_valid}, 32'd1);
            if (!pif.pkt_valid) break;
            chk("busy_emit", {31'b0, busy}, 32'd1);
            check_pkt(exp_q[k]);
            repeat (stall) @(negedge clk);
            if (stall > 0) begin
                chk("held_valid", {31'b0, pif.pkt_valid}, 32'd1);
                check_pkt(exp_q[k]);
            end
            pif.pkt_ready = 1'b1;
            @(negedge clk);
            pif.pkt_ready = 1'b0;
        end
        if (!scan) begin
            chk("reward_done", {31'b0, reward_done}, 32'd1);
        end else begin
            w = 0;
            while (!reward_done && w < 200) begin @(negedge clk); w++; end
            chk("scan_done", {31'b0, reward_done}, 32'd1);
        end
        chk("no_extra_pkt", {31'b0, pif.pkt_valid}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'b0, reward_done}, 32'd0);
        chk("idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic setup(input bit r, input logic [2:0] f, input logic [W-1:0] hc,
                         input bit dat, input bit le, input logic [W-1:0] hs);
        role = r; fPacketType = f; hopsFromCH = hc; iHaveData = dat; low_E = le;
        hopsFromSink = hs; iAmDestination = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, {31'b0, pif.pkt_valid}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, reward_done}, 32'd0);
        chk({tag, "_type"}, {29'b0, pif.rPacketType}, 32'd7);
        chk({tag, "_dest"}, {16'b0, pif.rDestinationID}, 32'h0000ffff);
        chk({tag, "_idx"}, {26'b0, nTableIndex}, 32'd0);
        chk({tag, "_src"}, {16'b0, pif.rSourceID}, 32'd0);
        chk({tag, "_ts"}, {16'b0, pif.rTimeslot}, 32'd0);
    endtask

    logic [2:0] ftypes [4];

    initial begin
        rst = 1'b1; en = 1'b0; pif.pkt_ready = 1'b0;
        setup(0, 3'b001, 0, 0, 0, 2);
        myNodeID = 16'h0042; myEnergy = 16'h0100; myQValue = 16'h0033;
        chosenCH = 16'h0077; chosenHop = 16'h0055; neighborCount = '0;
        for (int i = 0; i < 32; i++) begin tbl_node[i] = 16'(i + 100); tbl_ch[i] = 16'h0; end
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;
        @(negedge clk);

        // Heartbeat, locked repeat, Data unlocks, heartbeat again.
        setup(0, 3'b000, 0, 0, 0, 2); run_txn(0);
        run_txn(0);
        setup(0, 3'b000, 0, 1, 0, 2); run_txn(1);
        setup(0, 3'b000, 0, 0, 0, 2); run_txn(0);

        // Member INV ripple, hop limit, then MR after timeout.
        setup(0, 3'b010, 2, 0, 0, 2); run_txn(0);
        setup(0, 3'b010, 4, 0, 0, 2); run_txn(0);
        repeat (16) @(negedge clk);
        setup(0, 3'b001, 0, 0, 0, 2); run_txn(2);

        // CH: own INV, then CHT scan with entries 0 and 2 matching.
        neighborCount = 6'd3;
        tbl_node[0] = 16'h0a01; tbl_ch[0] = myNodeID;
        tbl_node[1] = 16'h0a02; tbl_ch[1] = 16'h0099;
        tbl_node[2] = 16'h0a03; tbl_ch[2] = myNodeID;
        setup(1, 3'b001, 0, 0, 0, 2); run_txn(0);
        repeat (17) @(negedge clk);
        run_txn(1);

        // Data to sink neighbour with 5-cycle backpressure, then SOS.
        setup(0, 3'b001, 0, 1, 0, 1); run_txn(5);
        setup(0, 3'b001, 0, 1, 1, 3); run_txn(0);

        // Reset mid-EMIT with an armed MR timer; nothing may survive.
        setup(0, 3'b010, 0, 0, 0, 2); run_txn(0);
        setup(0, 3'b000, 0, 0, 0, 2);
        en = 1'b1; @(negedge clk); en = 1'b0;
        chk("pre_rst_valid", {31'b0, pif.pkt_valid}, 32'd1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check_reset_state("mid_rst");
        model_reset();
        repeat (20) @(negedge clk);
        setup(0, 3'b001, 0, 0, 0, 2); run_txn(0);

        // Randomized requests against the model.
        ftypes[0] = 3'b000; ftypes[1] = 3'b010; ftypes[2] = 3'b101; ftypes[3] = 3'b001;
        for (int n = 0; n < 60; n++) begin
            role = 1'($urandom); fPacketType = ftypes[$urandom_range(0, 3)];
            hopsFromCH = 16'($urandom_range(0, 6)); iAmDestination = 1'($urandom);
            iHaveData = ($urandom_range(0, 3) == 0); low_E = 1'($urandom);
            hopsFromSink = 16'($urandom_range(0, 3));
            myNodeID = 16'($urandom); myEnergy = 16'($urandom); myQValue = 16'($urandom);
            chosenCH = 16'($urandom); chosenHop = 16'($urandom);
            neighborCount = 6'($urandom_range(0, 5));
            for (int i = 0; i < 8; i++) begin
                tbl_node[i] = 16'($urandom);
                tbl_ch[i]   = ($urandom_range(0, 1) == 1) ? myNodeID : 16'($urandom);
            end
            run_txn($urandom_range(0, 3));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/reward_packer.md
REWARD_PACKER -- requirements
Module: reward_packer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, width of every node-information field.
REQ-002 SHALL have parameter MAX_NEIGHBORS, default 32, neighbor-table depth; IDXW = clog2(MAX_NEIGHBORS)+1.
REQ-003 SHALL have parameter MAX_CH_HOPS, default 4, INV ripple limit.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 15, MR/CHT timer reload value (>=1).
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous and active-high.
REQ-006 SHALL have ports: en in 1, pack request; fPacketType in 3, filtered packet type; iAmDestination, iHaveData, role (1=CH), low_E, each in 1.
REQ-007 SHALL have ports: myNodeID, myEnergy, myQValue, hopsFromSink, chosenCH, hopsFromCH, chosenHop, each in WORD_WIDTH.
REQ-008 SHALL have ports: neighborCount in IDXW; nTableIndex out IDXW; mNodeID, mChosenCH, each in WORD_WIDTH, with 1-cycle read latency from nTableIndex.
REQ-009 SHALL have ports: pkt_valid out 1; pkt_ready in 1; rPacketType out 3; rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH, rTimeslot, each out WORD_WIDTH.
REQ-010 SHALL have ports: busy out 1, high whenever not IDLE; reward_done out 1, completion pulse.

Function
REQ-011 SHALL implement states IDLE, EMIT, CHT_RD, CHT_CHK, DONE; en SHALL be sampled only in IDLE and ignored otherwise.
REQ-012 SHALL, on en in IDLE, select the first match: (a) fPacketType=000 and !HBLock -> HB (000); (b) role and !invSent -> own INV (010), rHopsFromCH=0; (c) !role, fPacketType=010, hopsFromCH<MAX_CH_HOPS -> ripple INV (010), rHopsFromCH=hopsFromCH+1; (d) !role and mrPending -> MR (011); (e) role and chtPending -> CHT scan; (f) (iAmDestination and fPacketType=101) or iHaveData -> Data (101), or SOS (110) if low_E; (g) none -> DONE, pkt_valid stays 0.
REQ-013 SHALL, for (a)-(d),(f), register all fields on the en edge and assert pkt_valid the next cycle (1-cycle latency), in state EMIT.
REQ-014 SHALL source rSourceID=myNodeID, rEnergyLeft=myEnergy, rQValue=myQValue, rSourceHops=hopsFromSink, rChosenCH=chosenCH, rTimeslot=0 for all non-CHT packets.
REQ-015 SHALL set rDestinationID: HB/INV all-ones; MR chosenCH; Data/SOS 0 if hopsFromSink=1, else chosenHop; CHT the scanned mNodeID.
REQ-016 SHALL hold pkt_valid and all fields stable until pkt_valid and pkt_ready are both high; transfer completes on that cycle.
REQ-017 SHALL set HBLock on HB selection and clear it on Data/SOS transfer; set invSent on own-INV selection.
REQ-018 SHALL load the MR timer with TIMEOUT_CYCLES on case (c) if not already running/pending, and the CHT timer on case (b); each timer decrements every cycle and sets its pending flag on reaching 0, then stops.
REQ-019 SHALL clear mrPending on MR transfer and chtPending on CHT scan completion.
REQ-020 SHALL, in CHT scan, drive nTableIndex=i (0..neighborCount-1) in CHT_RD, compare mChosenCH=myNodeID in CHT_CHK; on match emit CHT (100) with rTimeslot=slot count starting at 1 via EMIT, then return to CHT_RD for i+1; non-match SHALL advance without emitting.
REQ-021 SHALL go from CHT scan directly to DONE when neighborCount=0 or after index neighborCount-1.
REQ-022 SHALL, after a non-CHT transfer or scan end, enter DONE, pulse reward_done for exactly one cycle, then return to IDLE.
REQ-023 SHALL not overflow rHopsFromCH: case (c) is excluded when hopsFromCH>=MAX_CH_HOPS.

Reset
REQ-024 SHALL, on rst at any clock edge including mid-packet or mid-scan, return to IDLE and drive pkt_valid=0, busy=0, reward_done=0, rPacketType=111, rDestinationID all-ones, nTableIndex=0, all other outputs 0.
REQ-025 SHALL clear HBLock, invSent, both timers and both pending flags on rst; a dropped packet SHALL not be re-emitted.

Verification
REQ-026 SHALL verify: en with fPacketType=000, pkt_ready=1 -> pkt_valid next cycle, rPacketType=000, dest FFFF, reward_done one cycle later; repeat en -> no packet until a Data transfer.
REQ-027 SHALL verify: member, fPacketType=010, hopsFromCH=2 -> INV rHopsFromCH=3; hopsFromCH=4 -> no packet; 15 cycles later en -> MR to chosenCH.
REQ-028 SHALL verify: CH, neighborCount=3, mChosenCH matches entries 0 and 2 -> two CHT packets, rTimeslot 1 and 2, dests mNodeID[0], mNodeID[2].
REQ-029 SHALL verify: Data with hopsFromSink=1, pkt_ready low 5 cycles -> fields stable, dest 0; low_E=1 -> rPacketType=110.
REQ-030 SHALL verify: rst asserted during EMIT with pkt_ready=0 -> next cycle pkt_valid=0, rPacketType=111, state IDLE, timers cleared.
